int_sched: RTL

//  Interrupt scheduler for the 5-stage datapath. Latches edges from 2 IO lines and 2 counter lines.

---
 rtl/int_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/int_sched.sv
// Interrupt scheduler: latches request edges, masks and prioritises them, and redirects
// fetch into a handler vector at a safe pipeline point and back to the saved PC on rti.
module int_sched #(
  parameter logic [31:0] IA0 = 32'h00000020,
  parameter logic [31:0] IA1 = 32'h00000020,
  parameter logic [31:0] IA2 = 32'h00000009,
  parameter logic [31:0] IA3 = 32'h00000009
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  input  logic        gie,
  input  logic        pipe_stall,
  input  logic        branch_busy,
  input  logic        rti,
  input  logic [31:0] resume_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_fd,
  output logic [31:0] epc,
  output logic        in_service,
  output logic [3:0]  int_taken,
  output logic [3:0]  pending,
  output logic [3:0]  mask
);

  typedef enum logic [2:0] {IDLE, ARM, ENTER, SERVICE, RET} state_t;

  state_t      state, state_nxt;
  logic [3:0]  irq_q;
  logic [3:0]  eligible;
  logic [3:0]  sel_onehot;
  logic [31:0] sel_vec;
  logic        rti_hold;
  logic        do_enter;
  logic        do_ret;

  assign eligible = pending & ~mask & {4{gie}};

  // Lowest index wins.
  always_comb begin
    sel_onehot = 4'b0000;
    sel_vec    = IA3;
    if (eligible[0]) begin
      sel_onehot = 4'b0001;
      sel_vec    = IA0;
    end else if (eligible[1]) begin
      sel_onehot = 4'b0010;
      sel_vec    = IA1;
    end else if (eligible[2]) begin
      sel_onehot = 4'b0100;
      sel_vec    = IA2;
    end else if (eligible[3]) begin
      sel_onehot = 4'b1000;
      sel_vec    = IA3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible) state_nxt = ARM;
      ARM: begin
        if (~|eligible)                      state_nxt = IDLE;
        else if (!pipe_stall && !branch_busy) state_nxt = ENTER;
      end
      ENTER:   state_nxt = SERVICE;
      SERVICE: if ((rti || rti_hold) && !pipe_stall) state_nxt = RET;
      RET:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_enter = (state == ARM) && (state_nxt == ENTER);
    do_ret   = (state == SERVICE) && (state_nxt == RET);
  end

  // Redirect outputs are registered so they are visible during the ENTER/RET cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q       <= 4'h0;
      pending     <= 4'h0;
      mask        <= 4'hF;
      redirect    <= 1'b0;
      flush_fd    <= 1'b0;
      redirect_pc <= 32'h0;
      epc         <= 32'h0;
      in_service  <= 1'b0;
      int_taken   <= 4'h0;
      rti_hold    <= 1'b0;
    end else begin
      irq_q    <= irq_in;
      redirect <= do_enter || do_ret;
      flush_fd <= do_enter || do_ret;
      // A fresh edge on the source being entered keeps it pending.
      pending  <= (pending & ~(do_enter ? sel_onehot : 4'h0)) | (irq_in & ~irq_q);
      if (mask_we) mask <= mask_wdata;
      if (do_enter) begin
        redirect_pc <= sel_vec;
        epc         <= resume_pc;
        int_taken   <= sel_onehot;
        in_service  <= 1'b1;
      end else if (do_ret) begin
        redirect_pc <= epc;
        int_taken   <= 4'h0;
        in_service  <= 1'b0;
      end
      if (do_ret)                                    rti_hold <= 1'b0;
      else if (state == SERVICE && rti && pipe_stall) rti_hold <= 1'b1;
    end
  end

endmodule
